uart_sram_tx_interface: RTL
===========================

# uart_sram_tx_interface

- Reads a block of 16-bit words from external SRAM through the SRAM controller port.
- Serialises each word onto the UART transmit line as two 8N1 frames, high byte first.
- Mirror of the UART receive path: it sends an image or decoded data segment back to the host PC.
- Sits beside the UART receive and VGA units; the top-level mux gives it the SRAM port while the top FSM is in the transmit state.

## Interface

Parameters:
- CLOCKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200 baud). Legal range is 2 or more.

Ports:
- CLOCK_50_I, input, 1: system clock.
- resetn, input, 1: reset, asynchronous, active-low.
- Start, input, 1: single-cycle request. Sampled only in S_TX_IDLE.
- Start_address, input, 18: first SRAM word address. Sampled with Start.
- Word_count, input, 18: number of words to send. Sampled with Start.
- SRAM_address, output, 18: read address to the SRAM controller.
- SRAM_we_n, output, 1: tied high. This block never writes SRAM.
- SRAM_read_data, input, 16: SRAM controller read data.
- UART_TX_O, output, 1: serial line. Idles high.
- Busy, output, 1: high from the cycle after an accepted Start until Done.
- Done, output, 1: one-cycle pulse when the block finishes.

## Operation

Reset values: UART_TX_O=1, Busy=0, Done=0, SRAM_address=0, SRAM_we_n=1, state=S_TX_IDLE, all counters 0.

State machine:
- S_TX_IDLE: on Start, latch the address and count.
  - Count of 0: pulse Done on the next cycle and stay idle. Nothing is transmitted and Busy stays low.
  - Otherwise: set Busy and go to S_TX_FETCH.
- S_TX_FETCH: drive SRAM_address, then go to S_TX_WAIT1.
- S_TX_WAIT1: go to S_TX_WAIT2.
- S_TX_WAIT2: capture SRAM_read_data into the word register (controller read latency is 2 cycles). Select the high byte and go to S_TX_START.
- S_TX_START: UART_TX_O=0 for CLOCKS_PER_BIT cycles.
- S_TX_DATA: send 8 bits LSB first, each for CLOCKS_PER_BIT cycles.
- S_TX_STOP: UART_TX_O=1 for CLOCKS_PER_BIT cycles. Then:
  - if the high byte was just sent: select the low byte and go to S_TX_START;
  - otherwise, if words remain: increment SRAM_address and go to S_TX_FETCH;
  - otherwise: pulse Done, clear Busy, go to S_TX_IDLE.

Arithmetic and boundaries:
- SRAM_address increments modulo 2^18, so 18'h3FFFF wraps to 0.
- The remaining-word counter is 18 bits and decrements once per word.
- Word_count=18'h3FFFF is legal.
- Start while Busy is ignored and has no side effects.
- Changing Start_address or Word_count after Start has no effect.
- SRAM_read_data is ignored outside S_TX_WAIT2.
- Asserting resetn low mid-frame returns every output to its reset value immediately. The partial frame is abandoned and the line goes high.

## Timing

- Start accepted in cycle 0. SRAM_address is valid in cycle 1, data is captured in cycle 3, and the start bit begins in cycle 4.
- Every bit lasts exactly CLOCKS_PER_BIT cycles with no jitter. The bit counter reloads at each bit boundary.
- Frame length is 10 × CLOCKS_PER_BIT, or 11 × with parity. The two frames of one word are back to back with no idle gap.
- Time per word is 3 + 2 × frame length. The SRAM fetch does not overlap transmission, so the line sits at idle high for 3 cycles between words.
- Done is high in the cycle after the last stop bit's final cycle. Busy falls in that same cycle.
- With N words, the request completes N × (3 + 2 × frame) + 1 cycles after Start.

## Configuration

- UART_TX_PARITY_EN defined:
  - an even-parity bit (XOR of the 8 data bits) is sent in state S_TX_PARITY, between S_TX_DATA and S_TX_STOP;
  - frame is 11 bits.
- Undefined: S_TX_PARITY is not compiled, and frames are plain 8N1 with 10 bits.

## Test plan

All scenarios use CLOCKS_PER_BIT=4 and a behavioural SRAM model with 2-cycle read latency.

- Single word:
  - Stimulus: Start_address=18'h00010, Word_count=1, mem[0x10]=16'hA53C.
  - Required: line shows 0, 1010 0101 LSB-first, 1, then 0, 0011 1100 LSB-first, 1. Done rises exactly 84 cycles after Start.
- Multi-word with wrap:
  - Stimulus: Start_address=18'h3FFFE, Word_count=3, mem = 0x1111, 0x2222, 0x3333 at 3FFFE, 3FFFF, 00000.
  - Required: bytes 11 11 22 22 33 33 are decoded in order, and SRAM_address reads 3FFFE, 3FFFF, 00000.
- Zero count:
  - Stimulus: Start with Word_count=0.
  - Required: Done pulses in cycle 1, Busy never rises, UART_TX_O stays 1.
- Start while busy:
  - Stimulus: a second Start with different inputs mid-transfer.
  - Required: the byte stream and Done timing are identical to the single-Start run.
- Reset mid-frame:
  - Stimulus: resetn low during a data bit.
  - Required: UART_TX_O=1, Busy=0, SRAM_address=0 the same cycle; a fresh Start afterwards transmits correctly.
- Parity build (UART_TX_PARITY_EN):
  - Stimulus: word 16'h0701.
  - Required: parity bits are 1 for 0x07 and 1 for 0x01, and Done comes 3 + 88 + 1 = 92 cycles after Start.

Source files
------------

// File: rtl/uart_sram_tx_interface.sv
// -----------------------------------------------------------------------------
// uart_sram_tx_interface
//
// Reads a block of 16-bit words from SRAM through the SRAM controller port and
// sends each word on the UART line as two frames, high byte first. Each frame
// is 8N1 by default: one start bit, 8 data bits LSB first, and one stop bit.
// This is the transmit counterpart of the UART receive unit. The top-level mux
// gives this block the SRAM port while the top FSM is in its transmit state.
//
// Optional build macro:
//   UART_TX_PARITY_EN - adds an even-parity bit (XOR of the 8 data bits)
//                       between the data bits and the stop bit, giving
//                       11-bit frames.
//
// Parameters:
//   CLOCKS_PER_BIT - clock cycles per UART bit (434 = 50 MHz / 115200).
//                    Must be 2 or more.
//
// Ports:
//   CLOCK_50_I     in   1   system clock
//   resetn         in   1   asynchronous reset, active-low
//   Start          in   1   single-cycle request, only sampled when idle
//   Start_address  in  18   first SRAM word address, sampled with Start
//   Word_count     in  18   number of words to send, sampled with Start
//   SRAM_address   out 18   read address to the SRAM controller
//   SRAM_we_n      out  1   write enable, always high (never writes)
//   SRAM_read_data in  16   read data from the SRAM controller
//   UART_TX_O      out  1   serial line, idles high
//   Busy           out  1   high while a request is being served
//   Done           out  1   one-cycle pulse when the request completes
// -----------------------------------------------------------------------------
module uart_sram_tx_interface #(
  parameter int CLOCKS_PER_BIT = 434
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int BAUD_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_FETCH,
    S_TX_WAIT1,
    S_TX_WAIT2,
    S_TX_START,
    S_TX_DATA,
`ifdef UART_TX_PARITY_EN
    S_TX_PARITY,
`endif
    S_TX_STOP
  } tx_state_t;

  tx_state_t         state_q, state_d;
  logic [17:0]       addr_q, addr_d;
  logic [17:0]       remain_q, remain_d;
  logic [15:0]       word_q, word_d;
  logic              hi_sel_q, hi_sel_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tx_q, tx_d;
  logic              bit_end;
  logic [7:0]        byte_d;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    even_parity = ^b;
  endfunction

  // Selects the byte being sent: the high byte goes first.
  function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic hi);
    pick_byte = hi ? w[15:8] : w[7:0];
  endfunction

  assign bit_end = (baud_q == BAUD_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    word_d   = word_q;
    hi_sel_d = hi_sel_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_TX_IDLE: begin
        if (Start) begin
          addr_d = Start_address;
          if (Word_count == 18'd0) begin
            // An empty request completes at once and never goes busy.
            done_d = 1'b1;
          end else begin
            remain_d = Word_count;
            busy_d   = 1'b1;
            state_d  = S_TX_FETCH;
          end
        end
      end

      S_TX_FETCH: state_d = S_TX_WAIT1;

      S_TX_WAIT1: state_d = S_TX_WAIT2;

      S_TX_WAIT2: begin
        // The controller returns data two cycles after the address cycle.
        word_d   = SRAM_read_data;
        hi_sel_d = 1'b1;
        baud_d   = '0;
        state_d  = S_TX_START;
      end

      S_TX_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_TX_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_TX_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_TX_PARITY;
`else
            state_d = S_TX_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      S_TX_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_TX_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif

      S_TX_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (hi_sel_q) begin
            // The low byte frame follows immediately with no idle gap.
            hi_sel_d = 1'b0;
            state_d  = S_TX_START;
          end else if (remain_q > 18'd1) begin
            remain_d = remain_q - 18'd1;
            addr_d   = addr_q + 18'd1;
            state_d  = S_TX_FETCH;
          end else begin
            remain_d = remain_q - 18'd1;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_TX_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: state_d = S_TX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Line level for the next cycle. It is decoded from the next-state values so
  // that the pin is driven by a flop and stays in step with state_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_d = pick_byte(word_d, hi_sel_d);
    tx_d   = 1'b1;
    case (state_d)
      S_TX_START:  tx_d = 1'b0;
      S_TX_DATA:   tx_d = byte_d[bit_d];
`ifdef UART_TX_PARITY_EN
      S_TX_PARITY: tx_d = even_parity(byte_d);
`endif
      default:     tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_TX_IDLE;
      addr_q   <= 18'd0;
      remain_q <= 18'd0;
      hi_sel_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      hi_sel_q <= hi_sel_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tx_q     <= tx_d;
    end
  end

  // The word register holds data only and is always loaded before use.
  always_ff @(posedge CLOCK_50_I) begin
    word_q <= word_d;
  end

  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign UART_TX_O    = tx_q;
  assign Busy         = busy_q;
  assign Done         = done_q;

endmodule
